// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order memory requests
// and buffers responses in a first-word-fall-through queue feeding IF/ID.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rdy_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc4   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic          err;

  logic          accept;
  logic          resp_ok;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_aligned;

  // Buffered plus in-flight instructions may never exceed the queue size,
  // which is what makes an overflow on push impossible.
  assign occupancy        = {1'b0, count} + {1'b0, outst};
  assign imem_req_o       = rst_i && !redirect_i && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr_o      = fetch_pc;
  assign accept           = imem_req_o && imem_rdy_i;
  assign resp_ok          = imem_rvalid_i && (outst != '0);
  assign push             = resp_ok && (drop == '0) && !redirect_i;
  assign pop              = instr_valid_o && instr_ready_i && !redirect_i;
  assign redirect_aligned = {redirect_pc_i[31:2], 2'b00};

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? q_instr[rd_ptr] : 32'h0;
  assign pc_plus4_o    = instr_valid_o ? q_pc4[rd_ptr]   : 32'h0;
  assign err_o         = err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      outst    <= '0;
      drop     <= '0;
      err      <= 1'b0;
    end else begin
      if (imem_rvalid_i && (outst == '0))
        err <= 1'b1;
      if (redirect_i) begin
        // Everything still in flight becomes a response to discard.
        fetch_pc <= redirect_aligned;
        resp_pc  <= redirect_aligned;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        outst    <= outst - CW'(resp_ok);
        drop     <= outst - CW'(resp_ok);
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + 32'd4;
        outst <= outst + CW'(accept) - CW'(resp_ok);
        if (resp_ok && (drop != '0))
          drop <= drop - CW'(1);
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata_i;
      q_pc4[wr_ptr]   <= resp_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized scoreboard bench for if_prefetch_queue: a variable-latency memory model
// feeds the DUT and a separate monitor checks every presented queue head.
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rdy_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        instr_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdy_i(imem_rdy_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_plus4_o(pc_plus4_o),
    .instr_ready_i(instr_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .err_o(err_o)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } mem_req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;

  mem_req_t    mem_q[$];
  exp_t        sb[$];
  logic [31:0] exp_fetch;
  bit          exp_err;
  bit          prev_redir;
  int          cyc, last_due;
  int          rdy_pct, take_pct, lat_min, lat_max;
  int          compared = 0;
  int          mismatched = 0;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic int staleCount();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, then model what the coming edge does.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc);
    bit       rsp;
    bit       exp_req;
    mem_req_t m;
    int       lat;
    @(posedge clk_i); #1;
    cyc++;
    rsp           = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    imem_rvalid_i = rsp;
    imem_rdata_i  = rsp ? memData(mem_q[0].addr) : $urandom;
    imem_rdy_i    = ($urandom_range(99) < rdy_pct);
    instr_ready_i = ($urandom_range(99) < take_pct);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
    if (prev_redir) checkOutput("flushed_valid", instr_valid_o, 0);
    checkOutput("err", err_o, exp_err);
    exp_req = !redir && (sb.size() + staleCount() < DEPTH);
    checkOutput("imem_req", imem_req_o, exp_req);
    if (imem_req_o && imem_rdy_i) begin
      checkOutput("imem_addr", imem_addr_o, exp_fetch);
      lat      = $urandom_range(lat_max, lat_min);
      m.addr   = exp_fetch;
      m.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      m.stale  = 1'b0;
      last_due = m.due;
      mem_q.push_back(m);
      sb.push_back('{instr: memData(exp_fetch), pc4: exp_fetch + 32'd4});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (rsp) void'(mem_q.pop_front());
    if (redir) begin
      sb.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_fetch = {rpc[31:2], 2'b00};
    end
    prev_redir = redir;
  endtask

  task automatic doReset();
    rst_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdy_i = 1'b0;
    redirect_i = 1'b0; instr_ready_i = 1'b0;
    #1;
    checkOutput("rst_req", imem_req_o, 0);
    checkOutput("rst_valid", instr_valid_o, 0);
    checkOutput("rst_instr", instr_o, 0);
    checkOutput("rst_pc4", pc_plus4_o, 0);
    checkOutput("rst_err", err_o, 0);
    mem_q.delete(); sb.delete();
    exp_fetch = RESET_PC; exp_err = 0; prev_redir = 0; last_due = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  // Monitor: compare every presented head against the oldest expected entry.
  always @(negedge clk_i) begin
    if (!redirect_i) begin
      if (instr_valid_o) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL stale_head: got pc_plus4 %h expected no instruction", pc_plus4_o);
        end else begin
          checkOutput("head_pc4", pc_plus4_o, sb[0].pc4);
          checkOutput("head_instr", instr_o, sb[0].instr);
          if (instr_ready_i) void'(sb.pop_front());
        end
      end else begin
        checkOutput("empty_instr", instr_o, 0);
        checkOutput("empty_pc4", pc_plus4_o, 0);
      end
    end
  end

  initial begin
    cyc = 0;
    doReset();

    // Streaming from reset with a 1-cycle memory
    rdy_pct = 100; take_pct = 100; lat_min = 1; lat_max = 1;
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b0, 32'h0);
      checkOutput("first_valid", instr_valid_o, (k == 3) ? 32'd1 : 32'd0);
    end
    repeat (20) applyStimulus(1'b0, 32'h0);

    // Decode stall fills the queue, then drains with no gap
    take_pct = 0;
    repeat (10) applyStimulus(1'b0, 32'h0);
    checkOutput("stall_valid", instr_valid_o, 1);
    checkOutput("stall_req", imem_req_o, 0);
    take_pct = 100;
    repeat (20) applyStimulus(1'b0, 32'h0);

    // Redirect with responses in flight on a 3-cycle memory
    lat_min = 3; lat_max = 3;
    repeat (10) applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0103);
    repeat (20) applyStimulus(1'b0, 32'h0);

    // Redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    repeat (10) applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0040);
    repeat (10) applyStimulus(1'b0, 32'h0);

    // Address wrap with random latency and readiness
    rdy_pct = 70; take_pct = 80; lat_min = 1; lat_max = 4;
    applyStimulus(1'b1, 32'hFFFF_FFF8);
    repeat (40) applyStimulus(1'b0, 32'h0);

    // Random traffic including back-to-back redirects
    for (int k = 0; k < 800; k++)
      applyStimulus($urandom_range(99) < 5, $urandom);

    // Reset with requests in flight
    rdy_pct = 100; take_pct = 100; lat_min = 3; lat_max = 3;
    begin
      int budget = 20;
      while (mem_q.size() < 2 && budget > 0) begin
        applyStimulus(1'b0, 32'h0);
        budget--;
      end
      checkOutput("inflight_before_reset", (mem_q.size() >= 2) ? 32'd1 : 32'd0, 1);
    end
    doReset();

    // Stray response with nothing outstanding
    @(posedge clk_i); #1;
    imem_rdy_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = $urandom;
    redirect_i = 1'b0; instr_ready_i = 1'b1;
    @(posedge clk_i); #1;
    imem_rvalid_i = 1'b0;
    exp_err = 1'b1;
    #1;
    checkOutput("err_set", err_o, 1);
    checkOutput("err_queue", instr_valid_o, 0);

    lat_min = 1; lat_max = 4; rdy_pct = 80; take_pct = 80;
    repeat (40) applyStimulus(1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register in the pipelined CPU.
- Owns the fetch PC and issues in-order instruction-memory requests through a ready/valid handshake that tolerates variable memory latency.
- Buffers returned instructions in a DEPTH-entry first-word-fall-through queue. Each entry is presented with its PC+4 to IF/ID.
- Honours decode-stage stalls (consumer ready low) and branch/jump redirects: the queue is flushed and in-flight responses are discarded.

Parameters:
DEPTH, 4, queue entries; power of two, 2..16; also caps in-flight plus buffered instructions
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active low
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  word-aligned fetch address; held stable while imem_req_o=1 and imem_rdy_i=0
imem_rdy_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  in-order response valid; arrives at least 1 cycle after acceptance
imem_rdata_i  in  32  response instruction
instr_valid_o  out  1  queue head valid
instr_o  out  32  head instruction; 0 when queue empty
pc_plus4_o  out  32  head instruction address + 4; 0 when queue empty
instr_ready_i  in  1  IF/ID accepts head (low = hazard stall)
redirect_i  in  1  flush and refetch from redirect_pc_i
redirect_pc_i  in  32  new fetch address; bits [1:0] ignored (treated as 0)
err_o  out  1  sticky protocol error flag

Behaviour:
- State: fetch_pc, resp_pc, queue storage with wr_ptr/rd_ptr/count, outst (in-flight count, 0..DEPTH), drop (in-flight responses to discard, 0..outst), err.
- Reset (rst_i=0, asynchronous): fetch_pc=resp_pc=RESET_PC; count=outst=drop=0; err=0.
  - Outputs under reset: imem_req_o=0, instr_valid_o=0, instr_o=0, pc_plus4_o=0, err_o=0.
  - Reset mid-transaction discards all state. Late responses arriving after reset with outst=0 set err (see below).
- Issue:
  - imem_req_o = !redirect_i && (count + outst < DEPTH). Combinational from registered state and redirect_i.
  - imem_addr_o = fetch_pc.
  - Accept = imem_req_o && imem_rdy_i. On accept: fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), outst += 1.
- Response (imem_rvalid_i=1):
  - outst -= 1.
  - If drop>0: drop -= 1 and the data is discarded.
  - Otherwise push {imem_rdata_i, resp_pc+4} and set resp_pc += 4.
  - Response with outst=0: ignored, err set. err clears only on reset.
- Output: FWFT.
  - instr_valid_o = (count != 0); instr_o and pc_plus4_o are the head entry.
  - Pop when instr_valid_o && instr_ready_i && !redirect_i.
  - Push and pop in the same cycle leave count unchanged. The issue cap guarantees no overflow.
  - A response arriving into an empty queue is visible on the following cycle (1-cycle buffer latency).
- Redirect (redirect_i=1 at an edge):
  - count=0 (queue cleared; no pop that cycle).
  - fetch_pc = resp_pc = {redirect_pc_i[31:2],2'b00}.
  - drop = outst - imem_rvalid_i; outst = outst - imem_rvalid_i. Every still-outstanding response becomes a drop.
  - No request is issued in the redirect cycle.
  - Redirect while drop>0 is legal; the formula subsumes the old drop.
  - Back-to-back redirects: the last one wins.
- Throughput: with a 1-cycle memory and imem_rdy_i=1, one instruction per cycle is sustained once the pipeline is primed.
- Latency: redirect at edge N -> request for the new PC at cycle N+1. With 1-cycle memory the response comes at N+2 and instr_valid_o=1 at cycle N+3 (earliest).
- Stall: with instr_ready_i=0, the queue fills to DEPTH-outst and imem_req_o drops. Head outputs hold stable.

Test Plan:
- Reset/stream: release reset with memory returning addr-derived data (rdata=addr^32'hA5A5_0000) at 1-cycle latency and ready always 1 -> addresses 0,4,8,... issued; instr_valid_o=1 from cycle 3 after reset; pc_plus4_o=4,8,12 each cycle with matching instr_o.
- Stall/backpressure: hold instr_ready_i=0 for 10 cycles -> exactly DEPTH=4 instructions buffered, imem_req_o=0, head stays pc_plus4_o=4. Release -> 4,8,12,16,... with no gap or duplicate.
- Redirect with in-flight: memory latency 3, 2 requests outstanding, redirect_pc_i=32'h0000_0103 -> both stale responses dropped, next request addr 32'h0000_0100, first delivered pc_plus4_o=32'h0000_0104.
- Redirect coincident with response and pop: redirect_i=1 in the same cycle as imem_rvalid_i=1 and instr_ready_i=1 -> no pop counted, drop=outst-1, queue empty next cycle, no stale instruction ever appears at the output.
- Variable latency/wrap: redirect to 32'hFFFF_FFF8, random ready/latency 1..4 -> delivered pc_plus4_o sequence FFFF_FFFC, 0000_0000, 0000_0004, in order.
- Reset mid-operation and protocol error: assert rst_i low with 2 requests in flight -> all outputs 0 immediately. A stray rvalid after reset -> err_o=1, queue unchanged.
